// File: rtl/sd_dat_response_rx.sv
`default_nettype none
// sd_dat_response_rx: receives the card's CRC-status token on DAT0 after a
// write block, tracks the busy period and reports a single registered result.
module sd_dat_response_rx #(
  parameter int CNT_W = 16
) (
  input  logic             sd_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dat_in,
  input  logic [CNT_W-1:0] TIMEOUT_REG,
  input  logic [CNT_W-1:0] BUSY_TIMEOUT,
  output logic [2:0]       status,
  output logic             accepted,
  output logic             crc_error,
  output logic             write_error,
  output logic             frame_error,
  output logic             timeout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    STATUS     = 3'd2,
    END_BIT    = 3'd3,
    BUSY       = 3'd4,
    DONE       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [1:0]       bit_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] start_limit;
  logic [CNT_W-1:0] busy_limit;

  // A programmed limit of zero behaves like one: terminal count is 0.
  always_comb begin
    start_limit = (TIMEOUT_REG == '0)  ? '0 : TIMEOUT_REG - CNT_ONE;
    busy_limit  = (BUSY_TIMEOUT == '0) ? '0 : BUSY_TIMEOUT - CNT_ONE;
  end

  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 2'd0;
      cyc_cnt     <= '0;
      status      <= 3'b000;
      accepted    <= 1'b0;
      crc_error   <= 1'b0;
      write_error <= 1'b0;
      frame_error <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (enable) begin
            status      <= 3'b000;
            accepted    <= 1'b0;
            crc_error   <= 1'b0;
            write_error <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            bit_cnt     <= 2'd0;
            cyc_cnt     <= '0;
            state       <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (!dat_in) begin
            cyc_cnt <= '0;
            state   <= STATUS;
          end else if (cyc_cnt == start_limit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end

        STATUS: begin
          status <= {status[1:0], dat_in};
          if (bit_cnt == 2'd2) begin
            bit_cnt <= 2'd0;
            state   <= END_BIT;
          end else begin
            bit_cnt <= bit_cnt + 2'd1;
          end
        end

        END_BIT: begin
          cyc_cnt <= '0;
          // A bad end bit or unknown token skips busy tracking entirely.
          if (!dat_in || !(status == 3'b010 || status == 3'b101 || status == 3'b110)) begin
            frame_error <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            accepted    <= (status == 3'b010);
            crc_error   <= (status == 3'b101);
            write_error <= (status == 3'b110);
            busy        <= 1'b1;
            state       <= BUSY;
          end
        end

        BUSY: begin
          if (dat_in) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cyc_cnt == busy_limit) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sd_dat_response_rx.md
# sd_dat_response_rx

Card-to-host CRC-status receiver for the SD DAT0 line, sitting directly downstream of `dat_phys` on write transfers. After the host shifts out a data block and its CRC16, it arms this block. The block then:
- waits for the card's start bit;
- captures the 3-bit CRC status token and checks the end bit;
- tracks the card busy period (DAT0 held low);
- reports a single completion result.

`dat_phys` uses the result to decide between `ack_out`/`complete` and error handling.

## Interface
Parameters:
- `CNT_W`, default 16: width of the start-bit and busy timeout counters.

Ports:
- `sd_clock`, in, 1: SD-side clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low. Sampled on the `sd_clock` rising edge; 0 resets the block.
- `enable`, in, 1: arm request, 1-cycle pulse or level. Honoured only in IDLE.
- `dat_in`, in, 1: DAT0 pin value, already synchronised to `sd_clock`.
- `TIMEOUT_REG`, in, `CNT_W`: maximum cycles to wait for the start bit.
- `BUSY_TIMEOUT`, in, `CNT_W`: maximum cycles DAT0 may stay low after the end bit.
- `status`, out, 3: captured token bits, MSB first on the wire.
- `accepted`, out, 1: `status` == 3'b010 and end bit == 1.
- `crc_error`, out, 1: `status` == 3'b101 and end bit == 1.
- `write_error`, out, 1: `status` == 3'b110 and end bit == 1.
- `frame_error`, out, 1: end bit == 0, or any other status code.
- `timeout`, out, 1: start-bit or busy timeout expired.
- `busy`, out, 1: high while in BUSY.
- `done`, out, 1: 1-cycle pulse when the result is valid.

## Operation
States: IDLE, WAIT_START, STATUS, END_BIT, BUSY, DONE.
- **IDLE:** `busy` = 0. If `enable` = 1:
  - clear all result flags, `status`, the bit counter and the cycle counter;
  - go to WAIT_START.
- **WAIT_START:** the cycle counter increments each cycle.
  - `dat_in` = 0 → STATUS, cycle counter cleared.
  - Otherwise, counter == `TIMEOUT_REG` − 1 → set `timeout` and go to DONE.
  - `TIMEOUT_REG` = 0 behaves as 1 (immediate timeout if no start bit on the first sampled cycle).
- **STATUS:** each cycle, `status` ← {`status`[1:0], `dat_in`}. The 2-bit counter counts 0..2; after the third bit → END_BIT.
- **END_BIT:** sample `dat_in`.
  - If 0, or `status` ∉ {010, 101, 110}: set `frame_error` and go to DONE. No busy tracking on a framing error.
  - Otherwise set the matching flag (`accepted`, `crc_error` or `write_error`) and go to BUSY.
- **BUSY:** `busy` = 1; the cycle counter increments.
  - `dat_in` = 1 → DONE.
  - Otherwise, counter == `BUSY_TIMEOUT` − 1 → set `timeout` and go to DONE; the status flag is kept.
- **DONE:** `done` = 1 for exactly one cycle → IDLE.
- **Result hold:** result flags and `status` hold from DONE until the next accepted `enable`.
- **Enable filtering:** `enable` outside IDLE is ignored. A level held high re-arms on the cycle after DONE.
- **Flag exclusivity:** exactly one of `accepted`/`crc_error`/`write_error`/`frame_error` may be set. `timeout` may coexist only with one of the three status flags (busy timeout).

## Timing
- **Reset values:** on `reset` = 0, state = IDLE and every output = 0 (`status` = 000, all flags 0, `busy` = 0, `done` = 0), counters = 0. Reset mid-transfer aborts without a `done` pulse.
- **Edge numbering:** `enable` high at edge E puts the block in WAIT_START from edge E. Start bit 0 sampled at edge S. Then:
  - status bits sampled at S+1, S+2, S+3;
  - end bit sampled at S+4;
  - BUSY from S+4.
- **Earliest done:** if `dat_in` = 1 at S+5, `done` is high during the cycle after S+5 (registered). This is the minimum latency.
- **Busy output:** `busy` is registered. It rises after edge S+4 and falls on the edge that samples `dat_in` = 1.
- **Start-bit timeout:** with no start bit, `done` is high after edge E + `TIMEOUT_REG`.
- **Counter width:** counters are `CNT_W` bits and never wrap, because the terminal-count check precedes the increment.

## Test plan
- **Accepted token:** `TIMEOUT_REG` = 100, `enable`, `dat_in` = 1,1,1,0,0,1,0,1 then 0 for 2 cycles then 1 → `status` = 010, `accepted` = 1, `busy` high for exactly 3 cycles, single `done` pulse, `timeout` = 0.
- **CRC error token:** sequence 0,1,0,1,1 then 1 → `crc_error` = 1, `status` = 101, `busy` high for 1 cycle, `done` once.
- **Start-bit timeout:** `TIMEOUT_REG` = 100, `dat_in` held 1 → `timeout` = 1, `done` exactly 100 cycles after arming, all other flags 0, `status` = 000.
- **Framing and busy timeout:**
  - sequence 0,0,1,0,0 (bad end bit) → `frame_error` = 1, no `busy`;
  - separately, a valid 010 token then `dat_in` held 0 with `BUSY_TIMEOUT` = 20 → `accepted` = 1, `timeout` = 1, `busy` high for 20 cycles.
- **Reset and enable filtering:**
  - `reset` = 0 during STATUS → all outputs 0 next edge, no `done`;
  - `enable` pulsed during BUSY → ignored, with a single `done`;
  - `enable` held high → re-arm one cycle after `done`.
